m62_rom_loader: RTL and testbench

//  Sits between data_io and the sdram controller / target_top PROM port of the Irem M62 core.

---
 rtl/m62_pkg.sv | 20 ++
 rtl/m62_toggle_port.sv | 78 +++++++
 rtl/m62_rom_loader.sv | 117 +++++++++++
 tb/tb_m62_rom_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m62_pkg.sv
// Irem M62 ROM download map and shared types for the ROM loader.
package m62_pkg;

  localparam int unsigned ADDR_W   = 25;
  localparam int unsigned PROM_AW  = 12;
  localparam int unsigned CNT_W    = 16;

  // A0000 map: 00000 CPU ROM, 30000 sprite gfx, 80000 gfx3, A0000 colour/height PROMs
  localparam logic [ADDR_W-1:0]  SP_BASE      = 25'h30000;
  localparam logic [ADDR_W-1:0]  GFX3_BASE    = 25'h80000;
  localparam logic [ADDR_W-1:0]  PROM_BASE    = 25'hA0000;
  localparam logic [PROM_AW-1:0] PROM_SIZE    = 12'h920;
  localparam logic [CNT_W-1:0]   RESET_CYCLES = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } req_state_t;

endpackage

// File: rtl/m62_toggle_port.sv
// One SDRAM toggle-handshake write port: latches byte/address, toggles req,
// tracks the pending write and flags a byte arriving while still pending.
module m62_toggle_port
  import m62_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        fire,
  input  logic        downl,
  input  logic        ack,
  input  logic [23:0] addr,
  input  logic [7:0]  data,
  output logic        req,
  output logic [22:0] a,
  output logic [1:0]  ds,
  output logic [15:0] d,
  output logic        we,
  output logic        overrun
);

  req_state_t  state_q, state_d;
  logic        req_d, overrun_d;
  logic [22:0] a_d;
  logic [1:0]  ds_d;
  logic [15:0] d_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      req     <= ack;
      a       <= '0;
      ds      <= '0;
      d       <= '0;
      we      <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      req     <= req_d;
      a       <= a_d;
      ds      <= ds_d;
      d       <= d_d;
      we      <= downl;
      overrun <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req;
    a_d       = a;
    ds_d      = ds;
    d_d       = d;
    overrun_d = overrun;

    // Every accepted byte is issued, even on top of an unacknowledged one
    if (fire) begin
      a_d   = addr[23:1];
      ds_d  = {addr[0], ~addr[0]};
      d_d   = {data, data};
      req_d = ~req;
    end

    case (state_q)
      IDLE: begin
        if (fire) state_d = BUSY;
      end
      BUSY: begin
        if (fire) begin
          if (req != ack) overrun_d = 1'b1;
          state_d = BUSY;
        end else if (req == ack) begin
          state_d = IDLE;
        end
      end
    endcase
  end

endmodule

// File: rtl/m62_rom_loader.sv
// Irem M62 ROM loader: ioctl byte stream to SDRAM toggle ports and PROM strobe,
// plus rom_loaded tracking and the core reset stretcher.
module m62_rom_loader #(
  parameter logic [24:0] SP_BASE      = m62_pkg::SP_BASE,
  parameter logic [24:0] PROM_BASE    = m62_pkg::PROM_BASE,
  parameter logic [11:0] PROM_SIZE    = m62_pkg::PROM_SIZE,
  parameter logic [15:0] RESET_CYCLES = m62_pkg::RESET_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  input  logic        port1_ack,
  input  logic        port2_ack,
  output logic        port1_req,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic [11:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic        prom_wr,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overrun
);

  logic        wr_last, downl_last;
  logic        accept_c, in_sdram_c, in_sp_c, in_prom_c;
  logic [24:0] prom_end_c;
  logic [23:0] sp_off_c;
  logic [11:0] prom_off_c;
  logic [15:0] rst_cnt;
  logic        ov1, ov2;

  // Range decisions use the raw address so a wrapped offset can never select a port
  assign accept_c   = ioctl_downl & ioctl_wr & ~wr_last;
  assign prom_end_c = PROM_BASE + 25'(PROM_SIZE);
  assign in_sdram_c = ioctl_addr < PROM_BASE;
  assign in_sp_c    = (ioctl_addr >= SP_BASE) && in_sdram_c;
  assign in_prom_c  = (ioctl_addr >= PROM_BASE) && (ioctl_addr < prom_end_c);
  assign sp_off_c   = 24'(ioctl_addr - SP_BASE);
  assign prom_off_c = 12'(ioctl_addr - PROM_BASE);

  m62_toggle_port u_port1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .fire    (accept_c & in_sdram_c),
    .downl   (ioctl_downl),
    .ack     (port1_ack),
    .addr    (ioctl_addr[23:0]),
    .data    (ioctl_dout),
    .req     (port1_req),
    .a       (port1_a),
    .ds      (port1_ds),
    .d       (port1_d),
    .we      (port1_we),
    .overrun (ov1)
  );

  m62_toggle_port u_port2 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .fire    (accept_c & in_sp_c),
    .downl   (ioctl_downl),
    .ack     (port2_ack),
    .addr    (sp_off_c),
    .data    (ioctl_dout),
    .req     (port2_req),
    .a       (port2_a),
    .ds      (port2_ds),
    .d       (port2_d),
    .we      (port2_we),
    .overrun (ov2)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_last    <= 1'b0;
      downl_last <= 1'b0;
      prom_wr    <= 1'b0;
      prom_addr  <= '0;
      prom_data  <= '0;
      rom_loaded <= 1'b0;
      rst_cnt    <= RESET_CYCLES;
      core_reset <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      wr_last    <= ioctl_wr;
      downl_last <= ioctl_downl;
      overrun    <= overrun | ov1 | ov2;

      prom_wr <= accept_c & in_prom_c;
      if (accept_c && in_prom_c) begin
        prom_addr <= prom_off_c;
        prom_data <= ioctl_dout;
      end

      if (ioctl_downl && !downl_last)      rom_loaded <= 1'b0;
      else if (!ioctl_downl && downl_last) rom_loaded <= 1'b1;

      // Any active cause reloads; otherwise count down to zero and stay there
      if (user_reset || !rom_loaded || ioctl_downl) rst_cnt <= RESET_CYCLES;
      else if (rst_cnt != 16'd0)                     rst_cnt <= rst_cnt - 16'd1;
      core_reset <= (rst_cnt != 16'd0);
    end
  end

endmodule

// File: tb/tb_m62_rom_loader.sv
// Scoreboard bench for m62_rom_loader: directed ioctl bytes, queued expectations
// popped by a monitor on each req toggle / prom_wr pulse.
module tb_m62_rom_loader;

  localparam logic [15:0] RC = 16'd20;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } port_exp_t;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } prom_exp_t;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_downl, ioctl_wr, user_reset, port1_ack, port2_ack;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_we, port2_req, port2_we;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic [11:0] prom_addr;
  logic [7:0]  prom_data;
  logic        prom_wr, rom_loaded, core_reset, overrun;

  port_exp_t q1[$];
  port_exp_t q2[$];
  prom_exp_t qp[$];

  int n_cmp = 0;
  int n_bad = 0;
  int tog1 = 0;
  int tog2 = 0;
  int nprom = 0;
  bit auto_ack1 = 1'b0;
  bit auto_ack2 = 1'b0;

  m62_rom_loader #(.RESET_CYCLES(RC)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .user_reset  (user_reset),
    .port1_ack   (port1_ack),
    .port2_ack   (port2_ack),
    .port1_req   (port1_req),
    .port1_a     (port1_a),
    .port1_ds    (port1_ds),
    .port1_d     (port1_d),
    .port1_we    (port1_we),
    .port2_req   (port2_req),
    .port2_a     (port2_a),
    .port2_ds    (port2_ds),
    .port2_d     (port2_d),
    .port2_we    (port2_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .prom_wr     (prom_wr),
    .rom_loaded  (rom_loaded),
    .core_reset  (core_reset),
    .overrun     (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input int len);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    repeat (len) tick();
    ioctl_wr = 1'b0;
    repeat (4) tick();
  endtask

  task automatic push_p1(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    port_exp_t e;
    e.a = a; e.ds = ds; e.d = d;
    q1.push_back(e);
  endtask

  task automatic push_p2(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    port_exp_t e;
    e.a = a; e.ds = ds; e.d = d;
    q2.push_back(e);
  endtask

  task automatic push_pr(input logic [11:0] a, input logic [7:0] d);
    prom_exp_t e;
    e.a = a; e.d = d;
    qp.push_back(e);
  endtask

  // SDRAM model: echoes the request toggle when enabled
  initial begin
    forever begin
      @(negedge clk_sys);
      if (auto_ack1) port1_ack = port1_req;
      if (auto_ack2) port2_ack = port2_req;
    end
  end

  // Monitor: pops an expectation on every req toggle or prom_wr pulse
  initial begin
    logic p1, p2, pw;
    bit   rs;
    port_exp_t e;
    prom_exp_t ep;
    pw = 1'b0;
    forever begin
      @(posedge clk_sys);
      rs = reset;
      #1;
      if (rs) begin
        p1 = port1_req;
        p2 = port2_req;
      end else begin
        if (port1_req !== p1) begin
          tog1++;
          if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL port1_unexpected: got toggle at a=%0h expected none", port1_a);
          end else begin
            e = q1.pop_front();
            chk("port1_payload", 64'({port1_a, port1_ds, port1_d}), 64'(e));
          end
          p1 = port1_req;
        end
        if (port2_req !== p2) begin
          tog2++;
          if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL port2_unexpected: got toggle at a=%0h expected none", port2_a);
          end else begin
            e = q2.pop_front();
            chk("port2_payload", 64'({port2_a, port2_ds, port2_d}), 64'(e));
          end
          p2 = port2_req;
        end
        if (prom_wr === 1'b1) begin
          nprom++;
          if (pw) begin
            n_cmp++; n_bad++;
            $display("FAIL prom_wr_width: got high 2+ cycles expected 1");
          end
          if (qp.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL prom_unexpected: got write at %0h expected none", prom_addr);
          end else begin
            ep = qp.pop_front();
            chk("prom_payload", 64'({prom_addr, prom_data}), 64'(ep));
          end
        end
      end
      pw = prom_wr;
    end
  end

  initial begin
    int n;
    reset = 1'b1; ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    user_reset = 1'b0; port1_ack = 1'b1; port2_ack = 1'b0;

    // 1: reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_port1_req", port1_req, 1);
    chk("rst_port2_req", port2_req, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_prom_wr", prom_wr, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_port1_a", port1_a, 0);
    chk("rst_port1_d", port1_d, 0);
    chk("rst_tog1", tog1, 0);
    auto_ack1 = 1'b1;
    auto_ack2 = 1'b1;

    // 2: single CPU byte, odd address
    ioctl_downl = 1'b1;
    tick(); tick();
    chk("dl_port1_we", port1_we, 1);
    chk("dl_port2_we", port2_we, 1);
    push_p1(23'h0, 2'b10, 16'h5A5A);
    write_byte(25'h00001, 8'h5A, 1);
    chk("t2_tog1", tog1, 1);
    chk("t2_tog2", tog2, 0);

    // 3: sprite byte mirrored to port2, long wr pulse
    push_p1(23'h18002, 2'b01, 16'hC3C3);
    push_p2(23'h00002, 2'b01, 16'hC3C3);
    write_byte(25'h30004, 8'hC3, 3);
    chk("t3_tog1", tog1, 2);
    chk("t3_tog2", tog2, 1);
    chk("t3_overrun", overrun, 0);

    // 4: PROM bytes, last valid PROM byte, and dropped bytes past the PROM area
    push_pr(12'h305, 8'h07);
    write_byte(25'hA0305, 8'h07, 1);
    push_pr(12'h91F, 8'h22);
    write_byte(25'hA091F, 8'h22, 1);
    write_byte(25'hA0920, 8'h99, 1);
    write_byte(25'h1FFFFFF, 8'h55, 1);
    chk("t4_nprom", nprom, 2);
    chk("t4_tog1", tog1, 2);
    chk("t4_tog2", tog2, 1);

    // 5: overrun with ack withheld
    auto_ack1 = 1'b0;
    push_p1(23'h8, 2'b01, 16'hAAAA);
    write_byte(25'h00010, 8'hAA, 1);
    chk("t5_no_overrun_yet", overrun, 0);
    push_p1(23'h8, 2'b10, 16'hBBBB);
    write_byte(25'h00011, 8'hBB, 1);
    chk("t5_overrun", overrun, 1);
    chk("t5_tog1", tog1, 4);
    auto_ack1 = 1'b1;
    repeat (3) tick();
    chk("t5_overrun_sticky", overrun, 1);
    chk("t5_acked", port1_req ^ port1_ack, 0);

    // 6: download end, reset stretcher and user_reset reload
    ioctl_downl = 1'b0;
    tick();
    chk("t6_rom_loaded", rom_loaded, 1);
    chk("t6_core_reset", core_reset, 1);
    repeat (4) tick();
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    n = 0;
    while (core_reset === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("t6_hold_cycles", n, 64'(RC) + 1);
    chk("t6_rom_loaded_kept", rom_loaded, 1);
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    tick();
    chk("t6_rearm", core_reset, 1);

    // 7: block reset mid-download drops the pending write
    ioctl_downl = 1'b1;
    tick(); tick();
    chk("t7_rom_loaded_clr", rom_loaded, 0);
    auto_ack1 = 1'b0;
    push_p1(23'h10, 2'b01, 16'h4444);
    write_byte(25'h00020, 8'h44, 1);
    chk("t7_pending", port1_req ^ port1_ack, 1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t7_no_pending", port1_req ^ port1_ack, 0);
    chk("t7_overrun_clr", overrun, 0);
    chk("t7_tog1", tog1, 5);
    chk("t7_core_reset", core_reset, 1);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("qp_drained", qp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
